// File: rtl/logic_reducer_pkg.sv
// Shared encodings for the logic_reducer block: operation codes, base-op
// selectors and FSM states.
package logic_reducer_pkg;

    localparam logic [2:0] OP_AND  = 3'd0;
    localparam logic [2:0] OP_OR   = 3'd1;
    localparam logic [2:0] OP_XOR  = 3'd2;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;
    localparam logic [2:0] OP_XNOR = 3'd6;

    localparam logic [1:0] BASE_AND = 2'd0;
    localparam logic [1:0] BASE_OR  = 2'd1;
    localparam logic [1:0] BASE_XOR = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/logic_reducer_reduce_word.sv
// Combinational reduction of a WIDTH-bit word to one bit under the base op.
// The reserved base op (3) falls back to AND.
module reduce_word
    import logic_reducer_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [1:0]       base_op,
    input  logic [WIDTH-1:0] data,
    output logic             result
);

    always_comb begin
        result = &data;
        case (base_op)
            BASE_OR:  result = |data;
            BASE_XOR: result = ^data;
            default:  result = &data;
        endcase
    end

endmodule

// File: rtl/logic_reducer.sv
// Handshaked multi-beat logic reducer: folds a packet of WIDTH-bit words into
// one verdict bit, with saturating beat count and overflow flag.
//
// state | meaning
// IDLE  | waiting for the first beat of a packet
// ACCUM | folding further beats into the accumulator
// HOLD  | result presented, waiting for out_ready
module logic_reducer
    import logic_reducer_pkg::*;
#(
    parameter int WIDTH     = 3,
    parameter int MAX_BEATS = 16,
    localparam int BW       = $clog2(MAX_BEATS + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_result,
    output logic [BW-1:0]    out_beats,
    output logic             out_overflow
);

    state_t          state_q, state_d;
    logic [2:0]      op_q;
    logic            acc_q;
    logic            res_q;
    logic [BW-1:0]   beats_q;
    logic            ovf_q;

    logic            first;
    logic            accept;
    logic [1:0]      base_op;
    logic            word_red;
    logic            fold_red;
    logic            acc_next;
    logic            invert;

    assign first   = (state_q == IDLE);
    assign accept  = in_valid && in_ready;
    // The op is live on the first beat and frozen in op_q afterwards.
    assign base_op = first ? in_op[1:0] : op_q[1:0];
    assign invert  = first ? in_op[2] : op_q[2];

    reduce_word #(.WIDTH(WIDTH)) u_word (
        .base_op (base_op),
        .data    (in_data),
        .result  (word_red)
    );

    // Folding the running bit with the new word's bit is itself a 2-bit reduction.
    reduce_word #(.WIDTH(2)) u_fold (
        .base_op (base_op),
        .data    ({acc_q, word_red}),
        .result  (fold_red)
    );

    assign acc_next = first ? word_red : fold_red;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = in_last ? HOLD : ACCUM;
            end
            ACCUM: begin
                in_ready = 1'b1;
                if (in_valid && in_last) state_d = HOLD;
            end
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= OP_AND;
            acc_q   <= 1'b0;
            res_q   <= 1'b0;
            beats_q <= '0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            acc_q <= acc_next;
            if (first) begin
                op_q    <= in_op;
                beats_q <= BW'(1);
                ovf_q   <= 1'b0;
            end else if (beats_q == BW'(MAX_BEATS)) begin
                ovf_q <= 1'b1;
            end else begin
                beats_q <= beats_q + BW'(1);
            end
            if (in_last) res_q <= acc_next ^ invert;
        end
    end

    assign out_result   = res_q;
    assign out_beats    = beats_q;
    assign out_overflow = ovf_q;

endmodule

// File: tb/tb_logic_reducer.sv
// Directed plus randomized bench for logic_reducer (WIDTH=3, MAX_BEATS=4),
// checked against a flattened-bit reference model.
module tb_logic_reducer;

    localparam int WIDTH = 3;
    localparam int MAXB  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_data = '0;
    logic       in_last = 1'b0;
    logic [2:0] in_op = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_result;
    logic [2:0] out_beats;
    logic       out_overflow;

    int n_checks = 0;
    int n_fails  = 0;
    logic [2:0] pkt_q[$];

    logic_reducer #(.WIDTH(WIDTH), .MAX_BEATS(MAXB)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_op        (in_op),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_beats    (out_beats),
        .out_overflow (out_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: the whole packet is one bag of bits; reduce it in one go.
    function automatic logic model_result(input logic [2:0] op);
        int ones = 0;
        int total = 0;
        logic r;
        foreach (pkt_q[i]) begin
            for (int b = 0; b < WIDTH; b++) begin
                ones += int'(pkt_q[i][b]);
                total++;
            end
        end
        case (op[1:0])
            2'd1:    r = (ones > 0);
            2'd2:    r = ((ones % 2) == 1);
            default: r = (ones == total);
        endcase
        return r ^ op[2];
    endfunction

    task automatic send_beats(input logic [2:0] op, input bit scramble, input bit close);
        int guard;
        for (int i = 0; i < pkt_q.size(); i++) begin
            in_valid = 1'b1;
            in_data  = pkt_q[i];
            in_last  = close && (i == pkt_q.size() - 1);
            in_op    = (i == 0 || !scramble) ? op : 3'($urandom_range(0, 7));
            guard = 0;
            while (in_ready !== 1'b1 && guard < 20) begin
                tick();
                guard++;
            end
            if (guard == 20) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_packet(input string tag, input logic [2:0] op, input int hold,
                              input bit scramble, input bit poke);
        logic exp_res;
        int   exp_beats;
        logic exp_ovf;
        exp_res   = model_result(op);
        exp_beats = (pkt_q.size() > MAXB) ? MAXB : pkt_q.size();
        exp_ovf   = (pkt_q.size() > MAXB);
        send_beats(op, scramble, 1'b1);
        chk({tag, "_valid"},  {31'd0, out_valid}, 32'd1);
        chk({tag, "_result"}, {31'd0, out_result}, {31'd0, exp_res});
        chk({tag, "_beats"},  {29'd0, out_beats}, 32'(exp_beats));
        chk({tag, "_ovf"},    {31'd0, out_overflow}, {31'd0, exp_ovf});
        for (int c = 0; c < hold; c++) begin
            if (poke) begin
                in_valid = 1'b1;
                in_last  = 1'b1;
                in_data  = 3'($urandom);
            end
            chk({tag, "_hold_ready"}, {31'd0, in_ready}, 32'd0);
            tick();
            chk({tag, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            chk({tag, "_hold_stable"}, {27'd0, out_result, out_beats, out_overflow},
                {27'd0, exp_res, 3'(exp_beats), exp_ovf});
        end
        out_ready = 1'b1;
        chk({tag, "_release_ready"}, {31'd0, in_ready}, 32'd0);
        tick();
        out_ready = 1'b0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        chk({tag, "_drop_valid"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        logic [2:0] w;
        int len;
        logic [2:0] op;

        // Reset state
        #12;
        chk("rst_valid",  {31'd0, out_valid}, 32'd0);
        chk("rst_result", {31'd0, out_result}, 32'd0);
        chk("rst_beats",  {29'd0, out_beats}, 32'd0);
        chk("rst_ovf",    {31'd0, out_overflow}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rst_ready", {31'd0, in_ready}, 32'd1);

        // Legacy 3-input AND truth table, single-beat packets
        for (int v = 0; v < 8; v++) begin
            w = 3'(v);
            pkt_q = '{w};
            run_packet($sformatf("and1_%0d", v), 3'd0, 0, 1'b0, 1'b0);
        end

        pkt_q = '{3'b111, 3'b111, 3'b110};
        run_packet("nand3", 3'd4, 0, 1'b0, 1'b0);
        run_packet("and3",  3'd0, 0, 1'b0, 1'b0);

        pkt_q = '{3'b001, 3'b011, 3'b111};
        run_packet("xor3",     3'd2, 0, 1'b0, 1'b0);
        run_packet("xnor3",    3'd6, 0, 1'b0, 1'b0);
        run_packet("xor3_tgl", 3'd2, 0, 1'b1, 1'b0);

        pkt_q = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000};
        run_packet("or_ovf", 3'd1, 0, 1'b0, 1'b0);

        pkt_q = '{3'b101, 3'b110};
        run_packet("backpr", 3'd1, 5, 1'b0, 1'b1);
        tick();
        chk("backpr_no_accept", {31'd0, out_valid}, 32'd0);

        // Reset in the middle of a packet
        pkt_q = '{3'b111, 3'b111};
        send_beats(3'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_beats", {29'd0, out_beats}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        pkt_q = '{3'b111};
        run_packet("after_rst", 3'd0, 0, 1'b0, 1'b0);

        // Randomized packets, including reserved ops 3 and 7
        for (int p = 0; p < 30; p++) begin
            len = $urandom_range(1, 6);
            op  = 3'($urandom_range(0, 7));
            pkt_q = {};
            for (int i = 0; i < len; i++) pkt_q.push_back(3'($urandom));
            run_packet($sformatf("rnd%0d", p), op, $urandom_range(0, 2),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
